seq_detector_prog: RTL and testbench

Runtime-programmable serial bit-pattern detector.
- Pattern up to MAX_LEN bits; length and overlap/non-overlap mode are programmable.
- Input bits are qualified by a valid strobe.
- Produces a one-cycle registered match pulse and a saturating match counter.
- Sits on a serial input stream in place of fixed-pattern detectors; the control block reprograms it through a single-cycle load strobe.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_detector_prog_if.sv | 27 ++
 rtl/sat_counter.sv | 24 ++
 rtl/seq_detector_prog.sv | 68 ++++++
 tb/tb_seq_detector_prog.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the programmable sequence detector
package seq_det_pkg;

    localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_1001;
    localparam int         DEFAULT_LEN     = 4;

    // Low len bits set; saturates to all ones for len >= 32.
    function automatic logic [31:0] len_mask(input int unsigned len);
        return (len >= 32) ? '1 : (32'd1 << len) - 32'd1;
    endfunction

    // Forces a programmed length into 1..max_len.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len == 32'd0) ? 32'd1 : (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_detector_prog_if.sv
// seq_detector_prog_if: stream, config and status bundle of the sequence detector
//   master: drives in_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count
//   slave : drives match, match_count, armed
interface seq_detector_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int COUNT_W = 16
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    logic               in_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               clr_count;
    logic               match;
    logic [COUNT_W-1:0] match_count;
    logic               armed;
    modport master (
        output in_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
        input  match, match_count, armed
    );
    modport slave (
        input  in_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
        output match, match_count, armed
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment
//   clk, reset : clock and asynchronous active-high reset
//   inc_i      : count one event
//   clr_i      : synchronous clear
//   count_o    : current count, sticks at all ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q, count_d;

    assign count_d = clr_i ? '0 : (inc_i && count_q != '1) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clk or posedge reset)
        if (reset) count_q <= '0;
        else       count_q <= count_d;

    assign count_o = count_q;
endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: runtime-programmable serial bit-pattern detector with match counter
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of seq_detector_prog_if (stream in, config load, match/count/armed out)
module seq_detector_prog #(
    parameter int                 MAX_LEN         = 8,
    parameter int                 COUNT_W         = 16,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = seq_det_pkg::DEFAULT_PATTERN,
    parameter int                 DEFAULT_LEN     = seq_det_pkg::DEFAULT_LEN
) (
    input  logic              clk,
    input  logic              reset,
    seq_detector_prog_if.slave bus
);
    import seq_det_pkg::*;

    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, mask, shifted;
    logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_inc, cfg_len_c;
    logic               ovl_q, ovl_d, match_q, armed_q, armed_d, hit;

    assign cfg_len_c = LEN_W'(clamp_len(32'(bus.cfg_len), MAX_LEN));
    // Pattern is stored raw; bits above len are masked out at compare time.
    assign mask      = MAX_LEN'(len_mask(32'(len_q)));
    assign shifted   = {hist_q[MAX_LEN-2:0], bus.din};
    assign fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    // Compare against the post-shift history so match lands one cycle after the completing bit.
    assign hit       = bus.in_valid && !bus.cfg_load && fill_inc >= len_q &&
                       ((shifted ^ pat_q) & mask) == '0;

    assign pat_d   = bus.cfg_load ? bus.cfg_pattern : pat_q;
    assign len_d   = bus.cfg_load ? cfg_len_c : len_q;
    assign ovl_d   = bus.cfg_load ? bus.cfg_overlap : ovl_q;
    assign hist_d  = bus.cfg_load ? '0 : bus.in_valid ? shifted : hist_q;
    // Non-overlap restarts the fill so the next match needs len fresh bits.
    assign fill_d  = bus.cfg_load ? '0 : !bus.in_valid ? fill_q : (hit && !ovl_q) ? '0 : fill_inc;
    assign armed_d = fill_d >= len_d;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pat_q   <= DEFAULT_PATTERN;
            len_q   <= LEN_W'(DEFAULT_LEN);
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= hit;
            armed_q <= armed_d;
        end

    sat_counter #(.W(COUNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (hit),
        .clr_i   (bus.clr_count),
        .count_o (bus.match_count)
    );

    assign bus.match = match_q;
    assign bus.armed = armed_q;
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed-vector bench for seq_detector_prog (16-bit and 4-bit counter builds)
module tb_seq_detector_prog;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    seq_detector_prog_if #(.MAX_LEN(8), .COUNT_W(16)) bus ();
    seq_detector_prog_if #(.MAX_LEN(8), .COUNT_W(4))  bus4 ();

    assign bus4.in_valid    = bus.in_valid;
    assign bus4.din         = bus.din;
    assign bus4.cfg_load    = bus.cfg_load;
    assign bus4.cfg_pattern = bus.cfg_pattern;
    assign bus4.cfg_len     = bus.cfg_len;
    assign bus4.cfg_overlap = bus.cfg_overlap;
    assign bus4.clr_count   = bus.clr_count;

    seq_detector_prog #(.MAX_LEN(8), .COUNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(bus));
    seq_detector_prog #(.MAX_LEN(8), .COUNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic d);
        bus.in_valid = v;
        bus.din      = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic feed(input string tag, input logic [31:0] bits, input int n, input logic [31:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i]);
            check(tag, 32'(bus.match), 32'(exp[i]));
        end
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic v, input logic d);
        bus.cfg_pattern = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = ov;
        bus.cfg_load    = 1'b1;
        bus.in_valid    = v;
        bus.din         = d;
        @(posedge clk);
        #1;
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b0;
        check("load_match", 32'(bus.match), 32'd0);
        check("load_armed", 32'(bus.armed), 32'd0);
    endtask

    initial begin
        bus.in_valid = 0; bus.din = 0; bus.cfg_load = 0; bus.cfg_pattern = '0;
        bus.cfg_len = '0; bus.cfg_overlap = 0; bus.clr_count = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_match", 32'(bus.match), 32'd0);
        check("rst_count", 32'(bus.match_count), 32'd0);
        check("rst_armed", 32'(bus.armed), 32'd0);

        feed("def_ovl", 32'b1001001, 7, 32'b0001001);
        check("def_count", 32'(bus.match_count), 32'd2);
        check("def_armed", 32'(bus.armed), 32'd1);

        load(8'b1001, 4'd4, 1'b0, 1'b0, 1'b0);
        check("load_keeps_count", 32'(bus.match_count), 32'd2);
        feed("nonovl", 32'b1001001001, 10, 32'b0001000001);
        check("nonovl_count", 32'(bus.match_count), 32'd4);
        load(8'b1001, 4'd4, 1'b1, 1'b0, 1'b0);
        feed("ovl", 32'b1001001001, 10, 32'b0001001001);
        check("ovl_count", 32'(bus.match_count), 32'd7);

        load(8'b1001, 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] b;
            b = 4'b1001;
            step(1'b1, b[i]);
            check("gap_bit", 32'(bus.match), 32'(i == 0));
            for (int j = 0; j < 3; j++) begin
                step(1'b0, j[0] ^ b[i] ^ 1'b1);
                check("gap_idle", 32'(bus.match), 32'd0);
            end
        end
        check("gap_count", 32'(bus.match_count), 32'd8);

        load(8'b1001, 4'd4, 1'b1, 1'b0, 1'b0);
        feed("pre_load", 32'b11, 2, 32'b00);
        load(8'b110, 4'd3, 1'b1, 1'b1, 1'b1);
        feed("post_load", 32'b0110, 4, 32'b0001);
        check("post_load_count", 32'(bus.match_count), 32'd9);
        load(8'b110, 4'd3, 1'b1, 1'b1, 1'b1);
        feed("load_discard", 32'b10, 2, 32'b00);

        load(8'hFD, 4'd0, 1'b1, 1'b0, 1'b0);
        feed("len0_clamp", 32'b1011, 4, 32'b1011);
        check("len0_count", 32'(bus.match_count), 32'd12);
        load(8'hA5, 4'd15, 1'b1, 1'b0, 1'b0);
        feed("len15_clamp", 32'b10100101, 8, 32'b00000001);
        check("len15_count", 32'(bus.match_count), 32'd13);

        load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        bus.clr_count = 1'b1;
        step(1'b0, 1'b0);
        bus.clr_count = 1'b0;
        check("clr_idle", 32'(bus.match_count), 32'd0);
        feed("sat_run", 32'hFFFFF, 20, 32'hFFFFF);
        check("sat_c16", 32'(bus.match_count), 32'd20);
        check("sat_c4", 32'(bus4.match_count), 32'd15);
        bus.clr_count = 1'b1;
        step(1'b1, 1'b1);
        bus.clr_count = 1'b0;
        check("clr_win_match", 32'(bus.match), 32'd1);
        check("clr_win_c4", 32'(bus4.match_count), 32'd0);
        check("clr_win_c16", 32'(bus.match_count), 32'd0);
        step(1'b1, 1'b1);
        check("after_clr_c4", 32'(bus4.match_count), 32'd1);

        load(8'b110, 4'd3, 1'b1, 1'b0, 1'b0);
        feed("pre_rst", 32'b110, 3, 32'b001);
        #2 reset = 1'b1;
        #1;
        check("async_match", 32'(bus.match), 32'd0);
        check("async_count", 32'(bus.match_count), 32'd0);
        check("async_c4", 32'(bus4.match_count), 32'd0);
        check("async_armed", 32'(bus.armed), 32'd0);
        #2 reset = 1'b0;
        feed("post_rst_def", 32'b1001, 4, 32'b0001);
        check("post_rst_count", 32'(bus.match_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
